// File: rtl/sram_axil_bridge.sv
// AXI4-Lite subordinate front-end for a single-port synchronous byte-enable RAM.
// Serves one transaction at a time. Reads and writes alternate on contention.
module sram_axil_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,

    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    output logic [1:0]                s_axil_bresp,

    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic [DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                s_axil_rresp,

    output logic [ADDR_WIDTH-1:0]     mem_raddr,
    output logic [ADDR_WIDTH-1:0]     mem_waddr,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    prio_rd_q, prio_rd_d;
    logic [ADDR_WIDTH-1:0]   mem_raddr_q, mem_raddr_d;
    logic [ADDR_WIDTH-1:0]   mem_waddr_q, mem_waddr_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    logic                    wr_eligible;
    logic                    rd_eligible;
    logic                    grant_wr;
    logic                    grant_rd;

    // Address bits above the RAM window and the byte offset are deliberately ignored.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{s_axil_awaddr, s_axil_araddr};

    // Arbitration: grant at most one eligible request while idle.
    // Gated by reset so no ready is offered while reset holds the FSM in IDLE.
    always_comb begin
        wr_eligible = s_axil_awvalid && s_axil_wvalid;
        rd_eligible = s_axil_arvalid;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        if ((state_q == IDLE) && reset) begin
            grant_wr = wr_eligible && (!rd_eligible || !prio_rd_q);
            grant_rd = rd_eligible && (!wr_eligible || prio_rd_q);
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            prio_rd_q   <= 1'b0;
            mem_raddr_q <= '0;
            mem_waddr_q <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_rd_q   <= prio_rd_d;
            mem_raddr_q <= mem_raddr_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    state_d = WR_RESP;
                end else if (grant_rd) begin
                    state_d = RD_WAIT;
                end
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    state_d = IDLE;
                end
            end
            RD_WAIT: begin
                state_d = RD_RESP;
            end
            RD_RESP: begin
                if (s_axil_rready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: capture on grant, strobes live for one cycle only.
    always_comb begin
        prio_rd_d   = prio_rd_q;
        mem_raddr_d = mem_raddr_q;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = '0;
        if (grant_wr) begin
            prio_rd_d   = 1'b1;
            mem_waddr_d = s_axil_awaddr[OFF+ADDR_WIDTH-1:OFF];
            mem_wdata_d = s_axil_wdata;
            mem_wstrb_d = s_axil_wstrb;
        end else if (grant_rd) begin
            prio_rd_d   = 1'b0;
            mem_raddr_d = s_axil_araddr[OFF+ADDR_WIDTH-1:OFF];
        end
    end

    // Bus-side outputs decoded from state and grant.
    always_comb begin
        s_axil_awready = grant_wr;
        s_axil_wready  = grant_wr;
        s_axil_arready = grant_rd;
        s_axil_bvalid  = (state_q == WR_RESP);
        s_axil_rvalid  = (state_q == RD_RESP);
        s_axil_rdata   = mem_rdata;
        s_axil_bresp   = 2'b00;
        s_axil_rresp   = 2'b00;
    end

    assign mem_raddr = mem_raddr_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_axil_bridge.sv
// Testbench for sram_axil_bridge: behavioural RAM, transaction-level model, directed stimulus.
module tb_sram_axil_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        s_axil_awvalid, s_axil_awready;
    logic [31:0] s_axil_awaddr;
    logic        s_axil_wvalid, s_axil_wready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_bvalid, s_axil_bready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_arvalid, s_axil_arready;
    logic [31:0] s_axil_araddr;
    logic        s_axil_rvalid, s_axil_rready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic [11:0] mem_raddr, mem_waddr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    sram_axil_bridge #(
        .ADDR_WIDTH    (12),
        .DATA_WIDTH    (32),
        .AXI_ADDR_WIDTH(32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .mem_raddr     (mem_raddr),
        .mem_waddr     (mem_waddr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    // Synchronous single-port RAM with byte enables and one cycle read latency.
    logic [31:0] ram [0:4095] = '{default: 32'h0};
    always @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) ram[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        mem_rdata <= ram[mem_raddr];
    end

    // Transaction-level expectation state.
    logic [31:0] m_mem [0:4095] = '{default: 32'h0};
    int          m_kind;   // 0 none in flight, 1 write, 2 read
    int          m_age;    // cycles elapsed since the grant
    logic        m_prio;   // reads win the next tie
    logic [11:0] m_waddr, m_raddr;
    logic [31:0] m_wdata, m_rexp;
    logic [3:0]  m_wstrb;

    logic [3:0]  w1_strb, w2_strb;
    logic [11:0] w1_addr;
    logic        w1_bv;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected handshake at %0t", nm, $time);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic cycle_checker();
        logic wr_e, rd_e, g_wr, g_rd, rv;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("rst_awready", 64'(s_axil_awready), 64'h0);
                chk("rst_wready",  64'(s_axil_wready),  64'h0);
                chk("rst_arready", 64'(s_axil_arready), 64'h0);
                chk("rst_bvalid",  64'(s_axil_bvalid),  64'h0);
                chk("rst_rvalid",  64'(s_axil_rvalid),  64'h0);
                chk("rst_wstrb",   64'(mem_wstrb),      64'h0);
                chk("rst_waddr",   64'(mem_waddr),      64'h0);
                chk("rst_raddr",   64'(mem_raddr),      64'h0);
                chk("rst_wdata",   64'(mem_wdata),      64'h0);
                m_kind = 0; m_age = 0; m_prio = 1'b0;
                m_waddr = '0; m_raddr = '0; m_wdata = '0; m_wstrb = '0; m_rexp = '0;
            end else begin
                wr_e = s_axil_awvalid && s_axil_wvalid;
                rd_e = s_axil_arvalid;
                g_wr = (m_kind == 0) && wr_e && (!rd_e || !m_prio);
                g_rd = (m_kind == 0) && rd_e && (!wr_e || m_prio);
                rv   = (m_kind == 2) && (m_age >= 2);
                chk("awready", 64'(s_axil_awready), 64'(g_wr));
                chk("wready",  64'(s_axil_wready),  64'(g_wr));
                chk("arready", 64'(s_axil_arready), 64'(g_rd));
                chk("bvalid",  64'(s_axil_bvalid),  64'(m_kind == 1));
                chk("rvalid",  64'(s_axil_rvalid),  64'(rv));
                if (rv) chk("rdata", 64'(s_axil_rdata), 64'(m_rexp));
                chk("mem_wstrb", 64'(mem_wstrb), 64'((m_kind == 1 && m_age == 1) ? m_wstrb : 4'h0));
                chk("mem_waddr", 64'(mem_waddr), 64'(m_waddr));
                chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
                chk("mem_raddr", 64'(mem_raddr), 64'(m_raddr));
                chk("bresp", 64'(s_axil_bresp), 64'h0);
                chk("rresp", 64'(s_axil_rresp), 64'h0);
                // A granted write lands in memory at the end of its first response cycle.
                if (m_kind == 1 && m_age == 1) begin
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_mem[m_waddr][b*8 +: 8] = m_wdata[b*8 +: 8];
                end
                if (g_wr) begin
                    m_kind = 1; m_age = 1; m_prio = 1'b1;
                    m_waddr = s_axil_awaddr[13:2]; m_wdata = s_axil_wdata; m_wstrb = s_axil_wstrb;
                end else if (g_rd) begin
                    m_kind = 2; m_age = 1; m_prio = 1'b0;
                    m_raddr = s_axil_araddr[13:2]; m_rexp = m_mem[s_axil_araddr[13:2]];
                end else if (m_kind == 1 && s_axil_bready) begin
                    m_kind = 0;
                end else if (rv && s_axil_rready) begin
                    m_kind = 0;
                end else if (m_kind != 0) begin
                    m_age++;
                end
            end
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bit got = 0;
        @(posedge clock); #1;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (s_axil_awready) begin got = 1; break; end
        end
        if (!got) timeout_fail("aw_grant");
        @(posedge clock); #1;
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        @(negedge clock);
        w1_strb = mem_wstrb; w1_addr = mem_waddr; w1_bv = s_axil_bvalid;
        @(negedge clock);
        w2_strb = mem_wstrb;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        bit got = 0;
        d = 32'hx; lat = 0;
        @(posedge clock); #1;
        s_axil_arvalid = 1'b1; s_axil_araddr = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (s_axil_arready) begin got = 1; break; end
        end
        if (!got) timeout_fail("ar_grant");
        @(posedge clock); #1;
        s_axil_arvalid = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            @(negedge clock);
            lat = i + 1;
            if (s_axil_rvalid) begin d = s_axil_rdata; got = 1; break; end
        end
        if (!got) timeout_fail("r_valid");
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        logic [3:0]  seq;
        int          ng;
        reset = 1'b0;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
        s_axil_awaddr = 0; s_axil_wdata = 0; s_axil_wstrb = 0; s_axil_araddr = 0;
        s_axil_bready = 1; s_axil_rready = 1;
        seq = '0;
        fork cycle_checker(); join_none

        // Reset with every valid asserted, then release: the write wins first.
        @(posedge clock); #1;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
        s_axil_awaddr = 32'h40; s_axil_wdata = 32'hA5A5A5A5; s_axil_wstrb = 4'hF; s_axil_araddr = 32'h10;
        repeat (3) begin
            @(negedge clock);
            chk("lit_rst_awready", 64'(s_axil_awready), 64'h0);
            chk("lit_rst_arready", 64'(s_axil_arready), 64'h0);
        end
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        chk("lit_first_awready", 64'(s_axil_awready), 64'h1);
        chk("lit_first_arready", 64'(s_axil_arready), 64'h0);
        @(posedge clock); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
        repeat (3) @(negedge clock);

        // Full write then read.
        do_write(32'h10, 32'hDEADBEEF, 4'hF);
        chk("lit_waddr", 64'(w1_addr), 64'h4);
        chk("lit_wstrb1", 64'(w1_strb), 64'hF);
        chk("lit_bvalid1", 64'(w1_bv), 64'h1);
        chk("lit_wstrb2", 64'(w2_strb), 64'h0);
        do_read(32'h10, d, lat);
        chk("lit_rd_lat", 64'(lat), 64'd2);
        chk("lit_rd_data", 64'(d), 64'hDEADBEEF);

        // Partial strobe, then a zero-strobe write.
        do_write(32'h10, 32'h11223344, 4'b0101);
        do_read(32'h10, d, lat);
        chk("lit_partial", 64'(d), 64'hDE22BE44);
        do_write(32'h10, 32'hFFFFFFFF, 4'h0);
        chk("lit_zero_strb_b", 64'(w1_bv), 64'h1);
        chk("lit_zero_strb_w", 64'(w1_strb), 64'h0);
        do_read(32'h10, d, lat);
        chk("lit_zero_strb_d", 64'(d), 64'hDE22BE44);

        // Contention: grants alternate starting with write.
        @(posedge clock); #1;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
        s_axil_awaddr = 32'h20; s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'hF; s_axil_araddr = 32'h20;
        ng = 0;
        for (int i = 0; i < 40; i++) begin
            if (ng < 4) begin
                @(negedge clock);
                if (s_axil_awready) begin seq[ng] = 1'b1; ng++; end
                else if (s_axil_arready) begin seq[ng] = 1'b0; ng++; end
            end
        end
        if (ng < 4) timeout_fail("contention");
        chk("lit_contention_seq", 64'(seq), 64'b0101);
        @(posedge clock); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
        repeat (5) @(negedge clock);

        // Read backpressure with competing requests held.
        s_axil_rready = 0;
        do_read(32'h20, d, lat);
        chk("lit_bp_data", 64'(d), 64'hCAFEF00D);
        @(posedge clock); #1;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_arvalid = 1;
        s_axil_awaddr = 32'h24; s_axil_wdata = 32'h0BADC0DE; s_axil_wstrb = 4'hF; s_axil_araddr = 32'h10;
        repeat (5) begin
            @(negedge clock);
            chk("lit_bp_rvalid", 64'(s_axil_rvalid), 64'h1);
            chk("lit_bp_rdata", 64'(s_axil_rdata), 64'hCAFEF00D);
            chk("lit_bp_awready", 64'(s_axil_awready), 64'h0);
            chk("lit_bp_arready", 64'(s_axil_arready), 64'h0);
        end
        @(posedge clock); #1 s_axil_rready = 1;
        @(negedge clock);
        @(negedge clock);
        chk("lit_after_rd_awready", 64'(s_axil_awready), 64'h1);
        @(posedge clock); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
        repeat (4) @(negedge clock);

        // Address without data is never accepted.
        @(posedge clock); #1;
        s_axil_awvalid = 1; s_axil_awaddr = 32'h28;
        repeat (4) begin
            @(negedge clock);
            chk("lit_stall_awready", 64'(s_axil_awready), 64'h0);
            chk("lit_stall_wready", 64'(s_axil_wready), 64'h0);
        end
        @(posedge clock); #1 s_axil_awvalid = 0;
        repeat (2) @(negedge clock);

        // Reset during the write-response cycle drops the write and its response.
        s_axil_bready = 0;
        begin
            bit got = 0;
            @(posedge clock); #1;
            s_axil_awvalid = 1; s_axil_wvalid = 1;
            s_axil_awaddr = 32'h30; s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF;
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (s_axil_awready) begin got = 1; break; end
            end
            if (!got) timeout_fail("mid_aw_grant");
        end
        @(posedge clock); #1;
        s_axil_awvalid = 0; s_axil_wvalid = 0;
        #1 reset = 1'b0;
        @(negedge clock);
        chk("lit_mid_wstrb", 64'(mem_wstrb), 64'h0);
        chk("lit_mid_bvalid", 64'(s_axil_bvalid), 64'h0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("lit_mid_no_b", 64'(s_axil_bvalid), 64'h0);
        end
        s_axil_bready = 1;
        do_read(32'h30, d, lat);
        chk("lit_mid_nowrite", 64'(d), 64'h0);
        do_read(32'h24, d, lat);
        chk("lit_rd_24", 64'(d), 64'h0BADC0DE);
        do_read(32'h10, d, lat);
        chk("lit_rd_10_final", 64'(d), 64'hDE22BE44);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
